// File: rtl/aud_ctrl_pkg.sv
// Shared types and constants for the audio mode sequencer.
package aud_ctrl_pkg;

  // Mode encodings, exported on o_state for the seven-segment display
  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_REC        = 3'd2,
    ST_REC_PAUSE  = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_e;

  localparam logic [3:0] SPEED_MIN = 4'd1;
  localparam logic [3:0] SPEED_MAX = 4'd8;

  typedef struct packed {
    logic [3:0] speed;
    logic       fast;
    logic       interp;
  } speed_cfg_t;

  // Raw switch speed field to playback speed: 0 reads as minimum, above 8 clamps
  function automatic logic [3:0] clamp_speed(input logic [3:0] raw);
    logic [3:0] r;
    if (raw < SPEED_MIN)      r = SPEED_MIN;
    else if (raw > SPEED_MAX) r = SPEED_MAX;
    else                      r = raw;
    return r;
  endfunction

endpackage

// File: rtl/aud_speed_decode.sv
// Registered speed/mode configuration, captured from the switches on a strobe.
module aud_speed_decode
  import aud_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_latch,
  input  logic [6:0] i_sw,
  output speed_cfg_t o_cfg
);

  speed_cfg_t r_cfg;
  logic       w_unused_sw6;

  assign w_unused_sw6 = i_sw[6];
  assign o_cfg        = r_cfg;

  // Capture the decoded switches only when the sequencer asks for it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg.speed  <= SPEED_MIN;
      r_cfg.fast   <= 1'b0;
      r_cfg.interp <= 1'b0;
    end else if (i_latch) begin
      r_cfg.speed  <= clamp_speed(i_sw[3:0]);
      r_cfg.fast   <= i_sw[4];
      r_cfg.interp <= i_sw[5];
    end
  end

endmodule

// File: rtl/aud_mode_ctrl.sv
// Central mode sequencer for the audio recorder/player.
// Optional build macro LOOP_PLAY_EN: end-of-recording during PLAY restarts
// playback instead of returning to IDLE.
module aud_mode_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]    MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_0,
  input  logic              i_key_1,
  input  logic              i_key_2,
  input  logic [6:0]        i_SW,
  input  logic              i_i2c_done,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_dsp_done,
  output logic [2:0]        o_state,
  output logic              o_i2c_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_sram_sel,
  output logic [3:0]        o_speed,
  output logic              o_fast,
  output logic              o_interp,
  output logic [ADDR_W-1:0] o_len
);

  state_e            r_state;
  logic              r_i2c_issued;
  logic              r_i2c_start, r_rec_start, r_rec_pause, r_rec_stop;
  logic              r_dsp_start, r_dsp_pause, r_dsp_stop;
  logic              r_sram_sel;
  logic [ADDR_W-1:0] r_len;

  state_e            w_state_nxt;
  logic              w_i2c_start, w_rec_start, w_rec_pause, w_rec_stop;
  logic              w_dsp_start, w_dsp_pause, w_dsp_stop;
  logic              w_sram_sel_nxt;
  logic [ADDR_W-1:0] w_len_nxt;
  logic              w_latch;
  speed_cfg_t        w_cfg;

  // Next-state and command decode; key2 outranks auto-stop, which outranks key0/key1
  always_comb begin
    w_state_nxt    = r_state;
    w_i2c_start    = 1'b0;
    w_rec_start    = 1'b0;
    w_rec_pause    = 1'b0;
    w_rec_stop     = 1'b0;
    w_dsp_start    = 1'b0;
    w_dsp_pause    = 1'b0;
    w_dsp_stop     = 1'b0;
    w_sram_sel_nxt = r_sram_sel;
    w_len_nxt      = r_len;
    w_latch        = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_i2c_start = ~r_i2c_issued;
        if (i_i2c_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_key_0) begin
          w_state_nxt    = ST_REC;
          w_rec_start    = 1'b1;
          w_sram_sel_nxt = 1'b1;
          w_len_nxt      = '0;
        end else if (i_key_1 && (r_len != '0)) begin
          w_state_nxt    = ST_PLAY;
          w_dsp_start    = 1'b1;
          w_sram_sel_nxt = 1'b0;
          w_latch        = 1'b1;
        end
      end
      ST_REC: begin
        if (i_key_2) begin
          w_state_nxt = ST_IDLE;
          w_rec_stop  = 1'b1;
          w_len_nxt   = i_rec_addr;
        end else if (i_rec_addr == MAX_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_rec_stop  = 1'b1;
          w_len_nxt   = MAX_ADDR;
        end else if (i_key_0) begin
          w_state_nxt = ST_REC_PAUSE;
          w_rec_pause = 1'b1;
        end
      end
      ST_REC_PAUSE: begin
        if (i_key_2) begin
          w_state_nxt = ST_IDLE;
          w_rec_stop  = 1'b1;
          w_len_nxt   = i_rec_addr;
        end else if (i_key_0) begin
          w_state_nxt = ST_REC;
          w_rec_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_key_2) begin
          w_state_nxt = ST_IDLE;
          w_dsp_stop  = 1'b1;
        end else if (i_dsp_done) begin
`ifdef LOOP_PLAY_EN
          w_dsp_start = 1'b1;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else if (i_key_1) begin
          w_state_nxt = ST_PLAY_PAUSE;
          w_dsp_pause = 1'b1;
        end
      end
      ST_PLAY_PAUSE: begin
        if (i_key_2) begin
          w_state_nxt = ST_IDLE;
          w_dsp_stop  = 1'b1;
        end else if (i_key_1) begin
          w_state_nxt = ST_PLAY;
          w_dsp_start = 1'b1;
          w_latch     = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State, command pulses, SRAM owner and recorded length registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_INIT;
      r_i2c_issued <= 1'b0;
      r_i2c_start  <= 1'b0;
      r_rec_start  <= 1'b0;
      r_rec_pause  <= 1'b0;
      r_rec_stop   <= 1'b0;
      r_dsp_start  <= 1'b0;
      r_dsp_pause  <= 1'b0;
      r_dsp_stop   <= 1'b0;
      r_sram_sel   <= 1'b0;
      r_len        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_i2c_issued <= 1'b1;
      r_i2c_start  <= w_i2c_start;
      r_rec_start  <= w_rec_start;
      r_rec_pause  <= w_rec_pause;
      r_rec_stop   <= w_rec_stop;
      r_dsp_start  <= w_dsp_start;
      r_dsp_pause  <= w_dsp_pause;
      r_dsp_stop   <= w_dsp_stop;
      r_sram_sel   <= w_sram_sel_nxt;
      r_len        <= w_len_nxt;
    end
  end

  aud_speed_decode u_speed_decode (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_latch (w_latch),
    .i_sw    (i_SW),
    .o_cfg   (w_cfg)
  );

  assign o_state     = r_state;
  assign o_i2c_start = r_i2c_start;
  assign o_rec_start = r_rec_start;
  assign o_rec_pause = r_rec_pause;
  assign o_rec_stop  = r_rec_stop;
  assign o_dsp_start = r_dsp_start;
  assign o_dsp_pause = r_dsp_pause;
  assign o_dsp_stop  = r_dsp_stop;
  assign o_sram_sel  = r_sram_sel;
  assign o_speed     = w_cfg.speed;
  assign o_fast      = w_cfg.fast;
  assign o_interp    = w_cfg.interp;
  assign o_len       = r_len;

endmodule
